// File: rtl/fir_lp_seq.sv
// Frame sequencer for the low-pass FIR path: primes the filter with NTAPS mid-scale words,
// streams ctrl_len samples through it and forwards ctrl_len filtered samples downstream.
module fir_lp_seq #(
    parameter int unsigned NTAPS      = 32,
    parameter int unsigned LEN_W      = 16,
    parameter logic [31:0] PRIME_DATA = 32'h0000_8000
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             ctrl_start,
    input  logic [LEN_W-1:0] ctrl_len,
    input  logic             ctrl_abort,
    output logic             stat_busy,
    output logic             stat_done,
    output logic             stat_abort,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      fir_tdata,
    output logic             fir_tvalid,
    input  logic             fir_tready,
    input  logic [31:0]      fir_r_tdata,
    input  logic             fir_r_tvalid,
    output logic             fir_r_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);
    localparam int unsigned   CW      = LEN_W + 1;
    localparam logic [CW-1:0] NTAPS_C = CW'(NTAPS);

    typedef enum logic [2:0] {StIdle, StPrime, StRun, StWait, StDrain} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic [CW-1:0]    total;
    logic             fir_hs, fir_r_hs;
    logic             win, discard, fwd;

    assign total    = NTAPS_C + CW'(len_q);
    assign fir_hs   = fir_tvalid & fir_tready;
    assign fir_r_hs = fir_r_tvalid & fir_r_tready;

    assign stat_busy  = (state_q != StIdle);
    assign stat_done  = done_q;
    assign stat_abort = abort_q;

    // Input side: priming words first, then a pass-through of the source stream.
    always_comb begin
        fir_tdata     = s_axis_tdata;
        fir_tvalid    = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            StPrime: begin
                fir_tdata  = PRIME_DATA;
                fir_tvalid = 1'b1;
            end
            StRun: begin
                fir_tvalid    = s_axis_tvalid;
                s_axis_tready = fir_tready;
            end
            default: ;
        endcase
    end

    // Output side is steered by out_cnt alone, so it keeps working across PRIME/RUN/WAIT.
    assign win     = (state_q != StIdle) && (state_q != StDrain);
    assign discard = (out_cnt_q < NTAPS_C);
    assign fwd     = !discard && (out_cnt_q < total);

    always_comb begin
        m_axis_tdata  = fir_r_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        fir_r_tready  = 1'b0;
        if (state_q == StDrain) begin
            fir_r_tready = 1'b1;
        end else if (win) begin
            if (discard) begin
                fir_r_tready = 1'b1;
            end else if (fwd) begin
                m_axis_tvalid = fir_r_tvalid;
                fir_r_tready  = m_axis_tready;
                m_axis_tlast  = (out_cnt_q == total - CW'(1));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q + CW'(fir_hs);
        out_cnt_d = out_cnt_q + CW'(fir_r_hs);
        done_d    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (ctrl_start) begin
                    state_d   = StPrime;
                    len_d     = ctrl_len;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            StPrime: begin
                if (fir_hs && (in_cnt_q == NTAPS_C - CW'(1))) begin
                    state_d = (len_q != '0) ? StRun : StWait;
                end
            end
            StRun: begin
                if (fir_hs && (in_cnt_q == total - CW'(1))) state_d = StWait;
            end
            StWait: begin
                if (out_cnt_d == total) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StDrain: begin
                if (out_cnt_q == in_cnt_q) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides any transition; the counters above still take this cycle's beats.
        if (ctrl_abort && (state_q inside {StPrime, StRun, StWait})) begin
            state_d = StDrain;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_fir_lp_seq.sv
// Scoreboard bench for fir_lp_seq with a 3-cycle FIR model that adds 4 to each word.
module tb_fir_lp_seq;
    localparam int          NT    = 4;
    localparam logic [31:0] PRIME = 32'h0000_8000;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b1;
    logic        ctrl_start, ctrl_abort;
    logic [15:0] ctrl_len;
    logic        stat_busy, stat_done, stat_abort;
    logic [31:0] s_axis_tdata, fir_tdata, fir_r_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, fir_tvalid, fir_tready;
    logic        fir_r_tvalid, fir_r_tready, m_axis_tvalid, m_axis_tready, m_axis_tlast;

    fir_lp_seq #(.NTAPS(NT), .LEN_W(16), .PRIME_DATA(PRIME)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ctrl_start    (ctrl_start),
        .ctrl_len      (ctrl_len),
        .ctrl_abort    (ctrl_abort),
        .stat_busy     (stat_busy),
        .stat_done     (stat_done),
        .stat_abort    (stat_abort),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .fir_tdata     (fir_tdata),
        .fir_tvalid    (fir_tvalid),
        .fir_tready    (fir_tready),
        .fir_r_tdata   (fir_r_tdata),
        .fir_r_tvalid  (fir_r_tvalid),
        .fir_r_tready  (fir_r_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {logic [31:0] d; logic l;} beat_t;
    typedef struct {logic [31:0] d; int rdy;} fent_t;

    beat_t       exp_m[$];
    logic [31:0] exp_fir[$];
    fent_t       fq[$];
    int errors = 0, checks = 0;
    int done_cnt = 0, abort_cnt = 0, n_fir = 0, n_firr = 0, n_m = 0, mcyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h, required no beat", name, act);
    endtask

    task automatic push_exp(input int len, input bit with_m);
        beat_t b;
        for (int i = 0; i < NT; i++) exp_fir.push_back(PRIME);
        for (int i = 1; i <= len; i++) begin
            exp_fir.push_back(32'(i));
            if (with_m) begin
                b.d = 32'(i + 4);
                b.l = (i == len);
                exp_m.push_back(b);
            end
        end
    endtask

    // FIR model: fixed 3-cycle latency, output = input + 4, head held until taken.
    initial begin
        fent_t e;
        fir_r_tvalid = 1'b0;
        fir_r_tdata  = '0;
        forever begin
            @(posedge aclk);
            mcyc++;
            #1;
            if (!aresetn) fq.delete();
            if (fq.size() > 0 && fq[0].rdy <= mcyc) begin
                fir_r_tvalid = 1'b1;
                fir_r_tdata  = fq[0].d;
            end else begin
                fir_r_tvalid = 1'b0;
            end
            #1;
            if (fir_r_tvalid && fir_r_tready) begin
                void'(fq.pop_front());
                n_firr++;
            end
            if (fir_tvalid && fir_tready) begin
                e.d   = fir_tdata + 32'd4;
                e.rdy = mcyc + 3;
                fq.push_back(e);
                n_fir++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a beat.
    initial begin
        beat_t b;
        forever begin
            @(posedge aclk);
            #2;
            if (fir_tvalid && fir_tready) begin
                if (exp_fir.size() == 0) fail_now("fir_extra_word", fir_tdata);
                else check("fir_word", fir_tdata, exp_fir.pop_front());
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_m++;
                if (exp_m.size() == 0) fail_now("m_extra_beat", m_axis_tdata);
                else begin
                    b = exp_m.pop_front();
                    check("m_data", m_axis_tdata, b.d);
                    check("m_last", 32'(m_axis_tlast), 32'(b.l));
                end
            end
            if (stat_done) begin
                done_cnt++;
                check("busy_at_done", 32'(stat_busy), 32'd0);
            end
            if (stat_abort) begin
                abort_cnt++;
                check("busy_at_abort", 32'(stat_busy), 32'd0);
            end
        end
    end

    // kill: 0 none, 1 abort after kill_at fir beats, 2 reset after kill_at source beats.
    task automatic run_frame(input int len, input bit rnd, input int kill, input int kill_at,
                             input int chain_len, input bit prestarted);
        int sent = 0, fhs = 0, age = 0;
        int d0 = done_cnt, a0 = abort_cnt, nf0 = n_fir, nr0 = n_firr, nm0 = n_m;
        bit last_hs = 0, killed = 0, chained = 0, finished = 0;
        if (!prestarted) begin
            @(posedge aclk);
            #1;
            push_exp(len, kill != 1);
            ctrl_len   = 16'(len);
            ctrl_start = 1'b1;
        end
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk);
            #1;
            if (chain_len >= 0 && stat_done) begin
                push_exp(chain_len, 1'b1);
                ctrl_start = 1'b1;
                ctrl_len   = 16'(chain_len);
                chained    = 1'b1;
            end else if (stat_busy && (i % 5 == 4)) begin
                ctrl_start = 1'b1;
                ctrl_len   = 16'd2;
            end else begin
                ctrl_start = 1'b0;
            end
            ctrl_abort = 1'b0;
            if (kill == 1 && !killed && fhs >= kill_at) begin
                ctrl_abort = 1'b1;
                killed     = 1'b1;
                age        = 1;
            end else if (age > 0) begin
                age++;
            end
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_axis_tvalid && !last_hs) begin
                // hold the pending beat
            end else if (sent < len && !killed) begin
                s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                s_axis_tdata  = 32'(sent + 1);
            end else begin
                s_axis_tvalid = 1'b0;
            end
            if (kill == 2 && sent >= kill_at) begin
                #3 aresetn = 1'b0;
                #1;
                check("rst_busy", 32'(stat_busy), 32'd0);
                check("rst_fir_tvalid", 32'(fir_tvalid), 32'd0);
                check("rst_s_tready", 32'(s_axis_tready), 32'd0);
                check("rst_fir_r_tready", 32'(fir_r_tready), 32'd0);
                check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
                check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
                check("rst_done", 32'(stat_done), 32'd0);
                killed = 1'b1;
                break;
            end
            #2;
            if (i == 0) begin
                check("prime_busy", 32'(stat_busy), 32'd1);
                check("prime_fir_tvalid", 32'(fir_tvalid), 32'd1);
                check("prime_fir_tdata", fir_tdata, PRIME);
            end
            if (age == 2) begin
                check("drain_busy", 32'(stat_busy), 32'd1);
                check("drain_s_tready", 32'(s_axis_tready), 32'd0);
                check("drain_fir_tvalid", 32'(fir_tvalid), 32'd0);
            end
            last_hs = s_axis_tvalid && s_axis_tready;
            if (last_hs) sent++;
            if (fir_tvalid && fir_tready) fhs++;
            if (done_cnt != d0 || abort_cnt != a0) begin
                finished = 1'b1;
                break;
            end
        end
        if (kill == 2) begin
            s_axis_tvalid = 1'b0;
            ctrl_start    = 1'b0;
            exp_fir.delete();
            exp_m.delete();
            repeat (3) @(posedge aclk);
            #4 aresetn = 1'b1;
        end else if (!finished) begin
            fail_now("frame_timeout", 32'(len));
        end else if (kill == 1) begin
            check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
            check("abort_abort_cnt", 32'(abort_cnt - a0), 32'd1);
            check("abort_fir_left", 32'(exp_fir.size()), 32'(NT + len - kill_at));
            check("abort_in_cnt", 32'(n_fir - nf0), 32'(kill_at));
            check("abort_out_cnt", 32'(n_firr - nr0), 32'(kill_at));
            check("abort_m_beats", 32'(n_m - nm0), 32'd0);
            check("abort_fir_empty", 32'(fq.size()), 32'd0);
            exp_fir.delete();
        end else begin
            check("done_cnt", 32'(done_cnt - d0), 32'd1);
            check("abort_cnt", 32'(abort_cnt - a0), 32'd0);
            check("in_cnt", 32'(n_fir - nf0), 32'(NT + len));
            check("out_cnt", 32'(n_firr - nr0), 32'(NT + len));
            check("m_beats", 32'(n_m - nm0), 32'(len));
            if (!chained) begin
                check("fir_exp_left", 32'(exp_fir.size()), 32'd0);
                check("m_exp_left", 32'(exp_m.size()), 32'd0);
            end
        end
    endtask

    initial begin
        ctrl_start    = 1'b0;
        ctrl_abort    = 1'b0;
        ctrl_len      = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        fir_tready    = 1'b1;
        m_axis_tready = 1'b1;
        #1 aresetn = 1'b0;
        #1;
        check("reset_busy", 32'(stat_busy), 32'd0);
        check("reset_done", 32'(stat_done), 32'd0);
        check("reset_abort", 32'(stat_abort), 32'd0);
        check("reset_fir_tvalid", 32'(fir_tvalid), 32'd0);
        check("reset_s_tready", 32'(s_axis_tready), 32'd0);
        check("reset_fir_r_tready", 32'(fir_r_tready), 32'd0);
        check("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_m_tlast", 32'(m_axis_tlast), 32'd0);
        repeat (3) @(posedge aclk);
        #4 aresetn = 1'b1;

        run_frame(8, 1'b0, 0, 0, 8, 1'b0);   // ramp frame, chains a new start in its done cycle
        run_frame(8, 1'b1, 0, 0, -1, 1'b1);  // same frame with random valid/ready
        run_frame(0, 1'b0, 0, 0, -1, 1'b0);  // prime only
        run_frame(8, 1'b0, 1, 6, -1, 1'b0);  // abort after 6 fir beats
        run_frame(8, 1'b0, 2, 3, -1, 1'b0);  // reset mid-RUN
        run_frame(2, 1'b0, 0, 0, -1, 1'b0);

        repeat (5) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
